// File: rtl/ysyx_23060171_stage_buf.sv
// Inter-unit valid/ready FIFO buffer with flush and transfer/stall counters; latency 1 cycle.
// Backpressure: in_ready drops only when full or flushing, with no pass-through from out_ready.
module ysyx_23060171_stage_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           xfer_cnt,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [OCC_W-1:0] r_occ;
  logic [CNT_W-1:0] r_xfer;
  logic [CNT_W-1:0] r_stall;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Pointers wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full    = (r_occ == OCC_W'(DEPTH));
  assign w_empty   = (r_occ == '0);
  assign in_ready  = !w_full && !flush;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_data  = r_mem[r_rp];
  assign occupancy = r_occ;
  assign xfer_cnt  = r_xfer;
  assign stall_cnt = r_stall;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else begin
      if (w_push) begin
        r_wp <= ptr_inc(r_wp);
      end
      if (w_pop) begin
        r_rp <= ptr_inc(r_rp);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Counters survive flush; a pop in the flush cycle still counts as a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xfer  <= '0;
      r_stall <= '0;
    end else begin
      if (w_pop) begin
        r_xfer <= r_xfer + CNT_W'(1);
      end
      if (in_valid && !in_ready) begin
        r_stall <= r_stall + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060171_stage_buf.sv
// Bench for ysyx_23060171_stage_buf: DEPTH=2 and DEPTH=3/CNT_W=4 instances share one stimulus stream.
// A queue per instance holds accepted payloads; the head is compared whenever out_valid is high.
module tb_ysyx_23060171_stage_buf;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  logic        ir2, ov2, ir3, ov3;
  logic [7:0]  od2, od3;
  logic [1:0]  occ2, occ3;
  logic [31:0] xc2, sc2;
  logic [3:0]  xc3, sc3;

  ysyx_23060171_stage_buf #(.WIDTH(8), .DEPTH(2), .CNT_W(32)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .occupancy(occ2), .xfer_cnt(xc2), .stall_cnt(sc2)
  );

  ysyx_23060171_stage_buf #(.WIDTH(8), .DEPTH(3), .CNT_W(4)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
    .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
    .occupancy(occ3), .xfer_cnt(xc3), .stall_cnt(sc3)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0]  q2[$];
  logic [7:0]  q3[$];
  int unsigned mx2 = 0, ms2 = 0, mx3 = 0, ms3 = 0;

  logic       s_ir2, s_ov2, s_ir3;
  logic [7:0] s_od2;
  logic [1:0] s_occ2;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_occ;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q2.delete();
    q3.delete();
    mx2 = 0; ms2 = 0; mx3 = 0; ms3 = 0;
  endtask

  // Drive one cycle, check both instances against the queue model at negedge, then advance the model.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    logic e_ir, e_ov;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    @(negedge clk);
    s_ir2 = ir2; s_ov2 = ov2; s_od2 = od2; s_occ2 = occ2; s_ir3 = ir3;

    e_ir = (q2.size() < 2) && !fl;
    e_ov = (q2.size() != 0);
    chk("d2_in_ready", 32'(ir2), 32'(e_ir));
    chk("d2_out_valid", 32'(ov2), 32'(e_ov));
    chk("d2_occupancy", 32'(occ2), 32'(q2.size()));
    if (e_ov) chk("d2_out_data", 32'(od2), 32'(q2[0]));
    chk("d2_xfer_cnt", xc2, mx2);
    chk("d2_stall_cnt", sc2, ms2);
    if (e_ov && ordy) mx2++;
    if (iv && !e_ir) ms2++;
    if (fl) q2.delete();
    else begin
      if (e_ov && ordy) void'(q2.pop_front());
      if (iv && e_ir) q2.push_back(d);
    end

    e_ir = (q3.size() < 3) && !fl;
    e_ov = (q3.size() != 0);
    chk("d3_in_ready", 32'(ir3), 32'(e_ir));
    chk("d3_out_valid", 32'(ov3), 32'(e_ov));
    chk("d3_occupancy", 32'(occ3), 32'(q3.size()));
    if (e_ov) chk("d3_out_data", 32'(od3), 32'(q3[0]));
    chk("d3_xfer_cnt", 32'(xc3), mx3 & 32'hF);
    chk("d3_stall_cnt", 32'(sc3), ms3 & 32'hF);
    if (e_ov && ordy) mx3++;
    if (iv && !e_ir) ms3++;
    if (fl) q3.delete();
    else begin
      if (e_ov && ordy) void'(q3.pop_front());
      if (iv && e_ir) q3.push_back(d);
    end

    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_d2_out_valid"}, 32'(ov2), 32'd0);
    chk({tag, "_d3_out_valid"}, 32'(ov3), 32'd0);
    chk({tag, "_d2_occupancy"}, 32'(occ2), 32'd0);
    chk({tag, "_d3_occupancy"}, 32'(occ3), 32'd0);
    chk({tag, "_d2_xfer"}, xc2, 32'd0);
    chk({tag, "_d3_xfer"}, 32'(xc3), 32'd0);
    chk({tag, "_d2_stall"}, sc2, 32'd0);
    chk({tag, "_d3_stall"}, 32'(sc3), 32'd0);
  endtask

  initial begin
    logic       iv;
    logic [7:0] d;

    // Stream through DEPTH=2 with out_ready held high.
    vecs[0] = '{iv: 1'b1, d: 8'h11, ordy: 1'b1, e_ir: 1'b1, e_ov: 1'b0, e_od: 8'h00, e_occ: 2'd0};
    vecs[1] = '{iv: 1'b1, d: 8'h22, ordy: 1'b1, e_ir: 1'b1, e_ov: 1'b1, e_od: 8'h11, e_occ: 2'd1};
    vecs[2] = '{iv: 1'b1, d: 8'h33, ordy: 1'b1, e_ir: 1'b1, e_ov: 1'b1, e_od: 8'h22, e_occ: 2'd1};
    vecs[3] = '{iv: 1'b0, d: 8'h00, ordy: 1'b1, e_ir: 1'b1, e_ov: 1'b1, e_od: 8'h33, e_occ: 2'd1};
    vecs[4] = '{iv: 1'b0, d: 8'h00, ordy: 1'b1, e_ir: 1'b1, e_ov: 1'b0, e_od: 8'h00, e_occ: 2'd0};

    #12;
    check_cleared("reset");
    chk("reset_d2_in_ready", 32'(ir2), 32'd1);
    chk("reset_d3_in_ready", 32'(ir3), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0);
      chk($sformatf("vec%0d_in_ready", i), 32'(s_ir2), 32'(vecs[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(s_ov2), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_occupancy", i), 32'(s_occ2), 32'(vecs[i].e_occ));
      if (vecs[i].e_ov) chk($sformatf("vec%0d_out_data", i), 32'(s_od2), 32'(vecs[i].e_od));
    end
    chk("stream_d2_xfer", xc2, 32'd3);
    chk("stream_d2_stall", sc2, 32'd0);

    // Fill DEPTH=3 under backpressure, hold the 4th payload, then drain.
    for (int k = 1; k <= 3; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    chk("fill_d3_in_ready_full", 32'(s_ir3), 32'd0);
    chk("fill_d3_occupancy", 32'(occ3), 32'd3);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b1, 1'b0);
    chk("fill_d3_no_passthrough", 32'(s_ir3), 32'd0);
    step(1'b1, 8'h44, 1'b1, 1'b0);
    chk("fill_d3_ready_after_pop", 32'(s_ir3), 32'd1);
    for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random interleave to walk the DEPTH=3 pointers round several times.
    iv = 1'b0;
    d = 8'h80;
    for (int k = 0; k < 60; k++) begin
      if (!iv || (s_ir2 && s_ir3)) begin
        iv = 1'($urandom_range(0, 1));
        d = d + 8'h01;
      end
      step(iv, d, 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with two entries held and a same-cycle input.
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b1, 1'b1);
    chk("flush_d2_in_ready", 32'(s_ir2), 32'd0);
    chk("flush_d3_in_ready", 32'(s_ir3), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_after_d2_out_valid", 32'(s_ov2), 32'd0);
    chk("flush_after_d2_occupancy", 32'(s_occ2), 32'd0);
    step(1'b1, 8'hB5, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_next_push_data", 32'(s_od2), 32'hB5);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset between edges with two entries held.
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_cleared("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 17 transfers: the 4-bit counter wraps to 1.
    for (int k = 0; k < 17; k++) step(1'b1, 8'(k), 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_d3_xfer", 32'(xc3), 32'd1);
    chk("wrap_d2_xfer", xc2, 32'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060171_stage_buf.md
# ysyx_23060171_stage_buf

Parametrised valid/ready buffer placed between consecutive CPU units (IFU→IDU, IDU→EXU, EXU→LSU, LSU→WBU) as the step from combinational unit-to-unit wiring to a handshaked multi-cycle and pipelined core. It carries one opaque payload bundle per transfer through a DEPTH-entry circular FIFO and supports a synchronous flush for redirects and traps. It has no combinational path from input to output or from `out_ready` to `in_ready`. Built-in counters report transfers and upstream stall cycles.

## Interface
Parameters:
- `WIDTH`, 64: payload width in bits. Each instance packs its stage signals (pc, inst, operands, control) into this width.
- `DEPTH`, 2: number of entries, ≥1. Need not be a power of two.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low. Asserting it clears all state immediately.
- `flush`  in  1  synchronous discard of all entries and of any same-cycle input.
- `in_valid`  in  1  upstream presents a payload.
- `in_ready`  out  1  buffer can accept a payload; equals `!full && !flush`.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  buffer holds at least one entry; equals `!empty`.
- `out_ready`  in  1  downstream accepts the head entry.
- `out_data`  out  WIDTH  head entry, driven from storage. Value is don't-care when `out_valid`=0.
- `occupancy`  out  $clog2(DEPTH+1)  number of valid entries.
- `xfer_cnt`  out  CNT_W  count of output handshakes.
- `stall_cnt`  out  CNT_W  count of cycles with `in_valid && !in_ready`.

## Operation
- Storage: DEPTH×WIDTH array, write pointer `wp`, read pointer `rp`, occupancy counter `occ`.
  - Both pointers wrap from DEPTH-1 to 0 by explicit compare, not by modulo-2^n.
  - `full` = (`occ`==DEPTH); `empty` = (`occ`==0).
- Push: `in_valid && in_ready` → write `in_data` at `wp`, then advance `wp`.
- Pop: `out_valid && out_ready` → advance `rp`.
- Occupancy update: `occ` += push − pop.
- Push and pop in the same cycle are legal when 0<`occ`<DEPTH; `occ` is unchanged.
- Full: `in_ready`=0 even if `out_ready`=1 in that cycle (no ready pass-through). This accepts a one-bubble penalty only when full.
- Empty: no bypass. A payload written in cycle N is visible on `out_data` no earlier than cycle N+1.
- Flush takes priority over everything in its cycle:
  - `wp`, `rp`, `occ` go to 0 at the edge.
  - `in_ready` is forced to 0, so no push occurs.
  - A pop handshake in the flush cycle still counts in `xfer_cnt`; the entry is discarded either way.
- Hold rule: while `out_valid && !out_ready`, `out_data` and `out_valid` stay stable (AXI-style). Upstream must likewise hold `in_data` while `in_valid && !in_ready`.
- Counters:
  - `xfer_cnt` increments on each pop handshake.
  - `stall_cnt` increments on each cycle with `in_valid && !in_ready`, including flush cycles.
  - Both wrap modulo 2^CNT_W. Flush does not clear them; only `rst` does.
- Reset values: `occupancy`=0, `out_valid`=0, `in_ready`=1 (when `flush`=0), `xfer_cnt`=0, `stall_cnt`=0, pointers 0. Storage contents are not reset.
- Reset mid-operation: all in-flight entries are lost. `out_valid` drops asynchronously on assertion.

## Timing
- Latency is 1 cycle: push at edge N gives `out_valid`=1 from N+1.
- Throughput:
  - DEPTH≥2: 1 transfer/cycle sustained with continuous valid/ready.
  - DEPTH=1: 1 transfer per 2 cycles (full blocks `in_ready`).
- `in_ready` depends only on registered state and `flush`.
- `out_valid` and `out_data` depend only on registered state.
- Flush seen at edge N: `out_valid`=0 from N+1. `in_ready`=1 again in the first cycle after `flush` deasserts.
- Release of `rst` is synchronised externally. The first push can occur at the first edge after deassertion.

## Test plan
- Reset, then stream with DEPTH=2: push 0x11,0x22,0x33 on consecutive cycles with `out_ready`=1. Expect outputs 0x11,0x22,0x33 on cycles 1,2,3; `occupancy` ≤1; `xfer_cnt`=3; `stall_cnt`=0.
- Fill and backpressure, DEPTH=3: `out_ready`=0, push 4 payloads. Expect `in_ready`=0 after 3 pushes, `occupancy`=3, `stall_cnt` +1 per held cycle. Raise `out_ready`: expect in-order drain, and `in_ready` returns the cycle after the first pop.
- Wrap-around, DEPTH=3 (non-power-of-two): 10 interleaved push/pop operations with random `out_ready`. Expect exact FIFO order and no loss or duplication. Exercise the pointer 2→0 wrap at least 3 times.
- Flush with 2 entries held plus `in_valid`=1: assert `flush` for 1 cycle. Expect `in_ready`=0 that cycle, `occupancy`=0 and `out_valid`=0 the next cycle. The same-cycle input is not delivered; the following push delivers normally.
- Async reset mid-stream: assert `rst`=0 between edges with `occupancy`=2. Expect `out_valid`=0 and counters=0 immediately, without waiting for a clock edge.
- Counter wrap, CNT_W=4: 17 transfers. Expect `xfer_cnt`=1.
